// File: rtl/axis_pkg.sv
// Shared constants for the AXI-Stream checksum packetizer.
// Holds the FSM state encoding and the packet counter width.
package axis_pkg;

    typedef enum logic [0:0] {
        DATA = 1'b0,
        SUM  = 1'b1
    } fsm_state_t;

    localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/axis_out_reg.sv
// Registered AXI-Stream output stage (valid/data/last) with slot-free indication.
// A new beat may be loaded whenever the slot is empty or its current beat is being taken.
module axis_out_reg #(
    parameter int AXIS_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [AXIS_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [AXIS_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  slot_free
);

    logic                  valid_r;
    logic [AXIS_WIDTH-1:0] data_r;
    logic                  last_r;

    assign slot_free     = !valid_r || m_axis_tready;
    assign m_axis_tvalid = valid_r;
    assign m_axis_tdata  = data_r;
    assign m_axis_tlast  = last_r;

    // Output beat register: load, drain, or hold while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            data_r  <= '0;
            last_r  <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
            last_r  <= load_last;
        end else if (slot_free) begin
            valid_r <= 1'b0;
            data_r  <= data_r;
            last_r  <= last_r;
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
            last_r  <= last_r;
        end
    end

endmodule

// File: rtl/axis_sum_packetizer.sv
// Forwards an AXI-Stream unchanged and appends a modular-sum checksum beat
// (tlast=1) after every PKT_LEN data beats; counts completed packets.
module axis_sum_packetizer
    import axis_pkg::*;
#(
    parameter int AXIS_WIDTH = 32,
    parameter int PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_axis_tvalid,
    input  logic [AXIS_WIDTH-1:0] s_axis_tdata,
    output logic                  s_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [AXIS_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [PKT_CNT_W-1:0]  pkt_count
);

    localparam int               CNT_W     = $clog2(PKT_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

    fsm_state_t             state_r;
    fsm_state_t             state_nxt_s;
    logic [AXIS_WIDTH-1:0]  acc_r;
    logic [AXIS_WIDTH-1:0]  acc_nxt_s;
    logic [CNT_W-1:0]       beat_cnt_r;
    logic [CNT_W-1:0]       beat_cnt_nxt_s;
    logic [PKT_CNT_W-1:0]   pkt_count_r;
    logic                   load_s;
    logic [AXIS_WIDTH-1:0]  load_data_s;
    logic                   load_last_s;
    logic                   slot_free_s;

    // Input is accepted only in DATA with room downstream, and never during reset.
    assign s_axis_tready = (state_r == DATA) && slot_free_s && !reset;
    assign pkt_count     = pkt_count_r;

    axis_out_reg #(
        .AXIS_WIDTH (AXIS_WIDTH)
    ) u_out_reg (
        .clk           (clk),
        .reset         (reset),
        .load          (load_s),
        .load_data     (load_data_s),
        .load_last     (load_last_s),
        .m_axis_tready (m_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .slot_free     (slot_free_s)
    );

    // Next-state, accumulator/counter update and output-load decisions.
    always_comb begin
        state_nxt_s    = state_r;
        acc_nxt_s      = acc_r;
        beat_cnt_nxt_s = beat_cnt_r;
        load_s         = 1'b0;
        load_data_s    = '0;
        load_last_s    = 1'b0;
        case (state_r)
            DATA: begin
                if (s_axis_tvalid && s_axis_tready) begin
                    load_s         = 1'b1;
                    load_data_s    = s_axis_tdata;
                    acc_nxt_s      = acc_r + s_axis_tdata;
                    beat_cnt_nxt_s = beat_cnt_r + CNT_W'(1);
                    if (beat_cnt_r == LAST_BEAT) begin
                        state_nxt_s = SUM;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else begin
                    state_nxt_s = DATA;
                end
            end
            SUM: begin
                if (slot_free_s) begin
                    load_s         = 1'b1;
                    load_data_s    = acc_r;
                    load_last_s    = 1'b1;
                    acc_nxt_s      = '0;
                    beat_cnt_nxt_s = '0;
                    state_nxt_s    = DATA;
                end else begin
                    state_nxt_s = SUM;
                end
            end
            default: begin
                state_nxt_s = DATA;
            end
        endcase
    end

    // State, accumulator and beat counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= DATA;
            acc_r      <= '0;
            beat_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            acc_r      <= acc_nxt_s;
            beat_cnt_r <= beat_cnt_nxt_s;
        end
    end

    // Completed-packet counter, advanced on each checksum-beat handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count_r <= '0;
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            pkt_count_r <= pkt_count_r + PKT_CNT_W'(1);
        end else begin
            pkt_count_r <= pkt_count_r;
        end
    end

endmodule

// File: doc/axis_sum_packetizer.md
AXIS_SUM_PACKETIZER -- requirements
Module: axis_sum_packetizer

Interface
REQ-001 Parameter AXIS_WIDTH, default 32, data width in bits of both streams.
REQ-002 Parameter PKT_LEN, default 4, number of data beats per packet; legal range is 1..65535.
REQ-003 Port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1, synchronous, active-high reset.
REQ-005 Port s_axis_tvalid, input, 1, upstream beat valid.
REQ-006 Port s_axis_tdata, input, AXIS_WIDTH, upstream beat data.
REQ-007 Port s_axis_tready, output, 1, block accepts the upstream beat.
REQ-008 Port m_axis_tvalid, output, 1, downstream beat valid.
REQ-009 Port m_axis_tdata, output, AXIS_WIDTH, downstream data or checksum.
REQ-010 Port m_axis_tlast, output, 1, marks the checksum beat, which is the final beat of a packet.
REQ-011 Port m_axis_tready, input, 1, downstream accepts the beat.
REQ-012 Port pkt_count, output, 16, number of completed packets (checksum beat handshaken), modulo 2^16.

Function
REQ-013 The block SHALL forward upstream beats unchanged, then after every PKT_LEN accepted beats insert one checksum beat with tlast=1.
REQ-014 The checksum SHALL equal the sum of the packet's PKT_LEN data words modulo 2^AXIS_WIDTH; carries are discarded.
REQ-015 All m_axis_* outputs SHALL come from registers; data latency from input handshake to m_axis_tvalid is exactly 1 cycle.
REQ-016 The output slot SHALL be "free" when m_axis_tvalid=0 or m_axis_tready=1.
REQ-017 The FSM SHALL have two states: DATA and SUM.
REQ-018 In DATA, s_axis_tready SHALL equal "slot free" and SHALL be 0 while reset=1.
REQ-019 In DATA, on an input handshake the block SHALL load s_axis_tdata into the output register with tlast=0, add the word to the accumulator, and increment the beat counter.
REQ-020 On the handshake where the beat counter equals PKT_LEN-1, the FSM SHALL go to SUM.
REQ-021 In SUM, s_axis_tready SHALL be 0.
REQ-022 In SUM, on the first cycle the slot is free, the block SHALL load the accumulator into the output register with tlast=1, clear the accumulator and beat counter, and return to DATA.
REQ-023 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast SHALL hold stable.
REQ-024 When the slot is free and no new beat is loaded, m_axis_tvalid SHALL go to 0 next cycle.
REQ-025 pkt_count SHALL increment on each output handshake with m_axis_tlast=1, wrapping 65535->0.
REQ-026 With m_axis_tready held at 1 and continuous input, sustained throughput SHALL be PKT_LEN input beats per PKT_LEN+1 cycles.
REQ-027 With PKT_LEN=1, each data beat SHALL be followed by a checksum beat equal to that data word.

Reset
REQ-028 While reset is asserted at a clock edge, the block SHALL drive m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, pkt_count=0, and clear the accumulator and beat counter, with the FSM in DATA.
REQ-029 Reset mid-packet SHALL discard the partial packet and any pending output beat; the next accepted beat starts a new packet.

Structure
REQ-030 The shared package axis_pkg SHALL hold the FSM state encoding constants (DATA, SUM) and the pkt_count width constant.
REQ-031 The output valid/data/last register with its slot-free logic SHALL be a sub-module named axis_out_reg; FSM, accumulator and counters stay in the top module.
REQ-032 The beat counter width SHALL be $clog2(PKT_LEN+1).

Verification (AXIS_WIDTH=32, PKT_LEN=4)
REQ-033 Inputs 1,2,3,4 with m_axis_tready=1 -> outputs 1,2,3,4 (tlast=0), then 10 (tlast=1); s_axis_tready=0 for the one SUM cycle; pkt_count=1.
REQ-034 Inputs 0xFFFFFFFF,0x1,0x0,0x0 -> checksum beat 0x00000000 with tlast=1.
REQ-035 m_axis_tready=0 for 5 cycles while data beat 0x55 is pending -> m_axis_tdata stays 0x55, s_axis_tready=0, and no input is lost after release.
REQ-036 Assert reset after 2 beats (7,9) are accepted, then send 5,6,7,8 -> outputs 5,6,7,8 then 26; pkt_count=1.
REQ-037 Send 65536 back-to-back packets with random m_axis_tready -> every checksum matches a reference sum, and pkt_count wraps to 0.
REQ-038 Sample outputs during reset -> m_axis_tvalid=0, s_axis_tready=0, pkt_count=0.
